// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences an external N-bit universal shift register
// (hold / shift-left / shift-right / parallel-load) for one job at a time.
// The job is accepted on a valid/ready handshake. The shifted word is
// returned on a response handshake.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN adds the req_rot input, which
// selects rotate instead of fill on a per-request basis.
module shift_sequencer #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_data,
  input  logic          req_dir,
  input  logic [AW-1:0] req_amt,
  input  logic          req_fill,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic          req_rot,
`endif
  output logic [1:0]    sh_ctrl,
  output logic [N-1:0]  sh_data,
  input  logic [N-1:0]  sh_q,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N-1:0]  resp_data,
  output logic          busy
);

  localparam logic [1:0] CTRL_HOLD  = 2'd0;
  localparam logic [1:0] CTRL_LEFT  = 2'd1;
  localparam logic [1:0] CTRL_RIGHT = 2'd2;
  localparam logic [1:0] CTRL_LOAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic          dir_q, dir_d;
  logic          fill_q, fill_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    sh_ctrl_q, sh_ctrl_d;
  logic [N-1:0]  sh_data_q, sh_data_d;
  logic          resp_valid_q, resp_valid_d;
  logic [N-1:0]  resp_data_q, resp_data_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic          rot_q, rot_d;
  logic [N-1:0]  sh_pred;
`endif

`ifdef SHIFT_SEQ_ROTATE_EN
  // Shifter contents after the coming edge; the wrap-around bit must be
  // registered one cycle ahead, so it is taken from this prediction.
  always_comb begin
    sh_pred = sh_q;
    case (sh_ctrl_q)
      CTRL_LEFT:  sh_pred = {sh_q[N-2:0], sh_data_q[0]};
      CTRL_RIGHT: sh_pred = {sh_data_q[N-1], sh_q[N-1:1]};
      CTRL_LOAD:  sh_pred = sh_data_q;
      default:    sh_pred = sh_q;
    endcase
  end
`endif

  // Next-state, job latch, result capture and registered shifter drive.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    dir_d        = dir_q;
    fill_d       = fill_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d        = rot_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          data_d  = req_data;
          dir_d   = req_dir;
          fill_d  = req_fill;
          cnt_d   = (req_amt > AW'(N)) ? AW'(N) : req_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d   = req_rot;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // First DONE cycle sees the final shifter value on sh_q.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_data_d  = sh_q;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sh_ctrl_d = CTRL_HOLD;
    sh_data_d = sh_data_q;
    case (state_d)
      ST_LOAD: begin
        sh_ctrl_d = CTRL_LOAD;
        sh_data_d = data_d;
      end
      ST_SHIFT: begin
        sh_ctrl_d = dir_d ? CTRL_RIGHT : CTRL_LEFT;
        sh_data_d = {N{fill_d}};
`ifdef SHIFT_SEQ_ROTATE_EN
        if (rot_d) begin
          if (dir_d) begin
            sh_data_d[N-1] = sh_pred[0];
          end else begin
            sh_data_d[0] = sh_pred[N-1];
          end
        end
`endif
      end
      default: sh_ctrl_d = CTRL_HOLD;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      dir_q        <= 1'b0;
      fill_q       <= 1'b0;
      cnt_q        <= '0;
      sh_ctrl_q    <= CTRL_HOLD;
      sh_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      dir_q        <= dir_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      sh_ctrl_q    <= sh_ctrl_d;
      sh_data_q    <= sh_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q        <= rot_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign sh_ctrl    = sh_ctrl_q;
  assign sh_data    = sh_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Request-driven controller that sequences an external N-bit universal shift register (hold / shift-left / shift-right / parallel-load, selected by a 2-bit control). It accepts one shift job per valid/ready handshake: load word, direction, shift amount and fill bit. It drives the shifter's control and data inputs cycle by cycle, then returns the shifted word on a response handshake. It sits between a command source and a single shifter instance, so the shifter is never driven by more than one job at a time.

## Interface
- N, 8: data width of the shifter; N ≥ 2.
- AW, $clog2(N)+1: width of the shift-amount field; encodes 0..N.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when state is IDLE.
- req_data  in  N  word to load into the shifter.
- req_dir  in  1  0 = shift left (toward MSB), 1 = shift right.
- req_amt  in  AW  number of single-bit shifts; values > N are clamped to N.
- req_fill  in  1  bit inserted at the vacated end on every shift.
- sh_ctrl  out  2  shifter control: 0 hold, 1 shift left (LSB ← sh_data[0]), 2 shift right (MSB ← sh_data[N-1]), 3 parallel load of sh_data.
- sh_data  out  N  shifter data input.
- sh_q  in  N  shifter register output.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  N  registered result word.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: sh_ctrl=0. On req_valid & req_ready, latch dir, clamped amt (into a down-counter), fill and data. Go to LOAD.
- LOAD: sh_ctrl=3, sh_data=latched data. Next: SHIFT if amt>0, else DONE.
- SHIFT: sh_ctrl=1 (dir=0) or 2 (dir=1). sh_data={N{fill}}. Counter decrements each cycle. Leave for DONE in the cycle the counter is 1.
- DONE: sh_ctrl=0. resp_data is captured from sh_q on entry. resp_valid=1 and is held with resp_data stable until resp_ready. On resp_valid & resp_ready go to IDLE.
- Clamp rule: amt ≥ N performs exactly N shifts, so the result is all fill bits (non-rotate build).
- Requests arriving while busy are not accepted. req_valid may stay high; it is sampled only in IDLE.
- Reset at any time forces IDLE, drops resp_valid and drives sh_ctrl=0 in the same cycle. A job in flight is discarded. The shifter contents are left as-is; the controller does not clear them.
- Reset values: req_ready=1, busy=0, sh_ctrl=0, sh_data=0, resp_valid=0, resp_data=0.

## Timing
- Request accepted at edge T. LOAD occupies cycle T..T+1. The shifts occupy the following amt cycles.
- resp_valid rises at edge T+2+amt. Example: amt=0 gives T+2; amt=N gives T+2+N.
- Back-to-back throughput: a new request can be accepted one cycle after the response handshake, at the earliest (IDLE is a full state).
- sh_ctrl and sh_data are registered outputs. The value for a state is present throughout that state's cycle.
- resp_data is never changed while resp_valid=1.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined:
  - Adds an input req_rot (1 bit), latched with the request.
  - When req_rot=1, each SHIFT cycle feeds the outgoing bit back in: left gives sh_data[0]=sh_q[N-1]; right gives sh_data[N-1]=sh_q[0].
  - amt=N returns the original word.
- SHIFT_SEQ_ROTATE_EN not defined: req_rot does not exist, and every shift inserts req_fill.

## Test plan
- N=8, data=8'hB5, dir=0, amt=3, fill=0 → resp_data=8'hA8, resp_valid at T+5.
- data=8'hB5, dir=1, amt=2, fill=1 → resp_data=8'hED; sh_ctrl sequence 3,2,2,0.
- amt=0, data=8'h3C → resp_data=8'h3C at T+2. amt=9 (clamped) with fill=1 → 8'hFF at T+10.
- Hold resp_ready=0 for 5 cycles with req_valid=1 → resp_data stable, req_ready=0, no second acceptance. Release → second job accepted ≥1 cycle later.
- Assert reset during SHIFT (cycle T+3) → sh_ctrl=0, resp_valid=0, req_ready=1 immediately; the next request completes normally.
- With SHIFT_SEQ_ROTATE_EN: data=8'h81, rot=1, dir=0, amt=1 → 8'h03. amt=8 → 8'h81.
